store_checker: RTL and testbench
================================

// Module: store_checker
// PURPOSE
//  Synthesizable verdict engine on the data-memory write port of the single-cycle
//  core (clk, reset, write_enab, data_addr, write_data). Classifies every store
//  as pass, allowed scratch or illegal, enforces a cycle budget and keeps a FIFO
//  log of accepted stores. Replaces ad-hoc negedge checks in benches and FPGA runs.
// PARAMETERS
//  PASS_ADDR      84   store address that signals success when data matches
//  PASS_DATA      7    required write_data at PASS_ADDR
//  SCRATCH_ADDR   80   address where stores are legal and do not end the run
//  TIMEOUT_CYCLES 1000 RUN cycles allowed before TIMEOUT (>=2)
//  LOG_DEPTH      8    store log entries (power of 2, >=2)
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  reset         in   1   synchronous, active-high; clears all state
//  write_enab    in   1   core store strobe
//  data_addr     in   32  core store address
//  write_data    in   32  core store data
//  done          out  1   verdict reached (PASS|FAIL|TIMEOUT)
//  pass          out  1   state==PASS
//  fail          out  1   state==FAIL
//  timeout       out  1   state==TIMEOUT
//  store_count   out  16  stores accepted in RUN, saturates at 16'hFFFF
//  cycle_count   out  32  RUN cycles elapsed
//  bad_addr      out  32  address of the store that caused FAIL, else 0
//  bad_data      out  32  data of that store, else 0
//  log_rd_en     in   1   pop log head
//  log_empty     out  1   log has no entries
//  log_full      out  1   log holds LOG_DEPTH entries
//  log_overflow  out  1   sticky: a store was dropped because log was full
//  log_addr      out  32  head entry address (valid when !log_empty)
//  log_data      out  32  head entry data (valid when !log_empty)
// BEHAVIOUR
//  - Reset (sync, priority over everything): state=RUN, all counters/regs 0,
//    log empty, log_overflow=0; all outputs 0 except log_empty=1.
//  - States: RUN, PASS, FAIL, TIMEOUT. PASS/FAIL/TIMEOUT sticky until reset.
//  - RUN, write_enab=1 at edge, priority order:
//    addr==PASS_ADDR && data==PASS_DATA -> PASS;
//    addr==SCRATCH_ADDR -> stay RUN; any other store -> FAIL, latch bad_addr/bad_data.
//    (PASS_ADDR with wrong data is illegal -> FAIL.)
//  - Verdict is registered: pass/fail visible the cycle after the store edge.
//  - cycle_count increments each edge in RUN, frozen in terminal states.
//    On the edge where cycle_count==TIMEOUT_CYCLES-1 with no store verdict ->
//    TIMEOUT. A PASS or FAIL store on that same edge wins over TIMEOUT.
//  - Every store in RUN, including the one causing PASS/FAIL, increments
//    store_count and pushes {addr,data} to the log. Stores in terminal states ignored.
//  - Log: circular buffer, head shown combinationally on log_addr/log_data.
//    Pop on log_rd_en && !log_empty; pop when empty ignored, no state change.
//    Push when full with no pop: entry dropped, log_overflow<=1.
//    Push and pop on the same edge when full: both happen, no overflow, count unchanged.
//    Push and pop on the same edge when empty: push only.
//    Pointers wrap modulo LOG_DEPTH; log readable in all states.
// TESTING
//  1 reset 2 cycles; stores (80,5),(84,7) -> pass=1 cycle after 2nd store, store_count=2, log=(80,5),(84,7)
//  2 store (84,6) -> fail=1, bad_addr=84, bad_data=6; later (84,7) ignored, store_count=1
//  3 TIMEOUT_CYCLES=20, no stores -> timeout=1 after 20 RUN edges, cycle_count=20 frozen
//  4 TIMEOUT_CYCLES=20, store (84,7) on edge 20 -> pass=1, timeout=0
//  5 LOG_DEPTH=8, 10 stores to 80 -> log_full=1, log_overflow=1, 8 pops return first 8 in order, then log_empty=1
//  6 log full, push+pop same edge -> no overflow, log_full stays 1; reset mid-run -> all outputs as reset

Source files
------------

// File: rtl/store_checker.sv
// Verdict engine on the core's data-memory write port.
// Classifies stores, enforces a cycle budget and logs accepted stores.
module store_checker #(
    parameter logic [31:0] PASS_ADDR      = 32'd84,
    parameter logic [31:0] PASS_DATA      = 32'd7,
    parameter logic [31:0] SCRATCH_ADDR   = 32'd80,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          LOG_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enab,
    input  logic [31:0] data_addr,
    input  logic [31:0] write_data,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [15:0] store_count,
    output logic [31:0] cycle_count,
    output logic [31:0] bad_addr,
    output logic [31:0] bad_data,
    input  logic        log_rd_en,
    output logic        log_empty,
    output logic        log_full,
    output logic        log_overflow,
    output logic [31:0] log_addr,
    output logic [31:0] log_data
);

    localparam int AW = $clog2(LOG_DEPTH);
    localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [31:0] mem_addr [LOG_DEPTH];
    logic [31:0] mem_data [LOG_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic run;
    logic push;
    logic pop;
    logic push_ok;
    logic pass_hit;
    logic scratch_hit;
    logic latch_bad;

    assign run         = (state == S_RUN);
    assign push        = run && write_enab;
    assign log_empty   = (count == '0);
    assign log_full    = count[AW];
    assign pop         = log_rd_en && !log_empty;
    // A full log still accepts a store when the head leaves on the same edge.
    assign push_ok     = push && (!log_full || pop);
    assign pass_hit    = (data_addr == PASS_ADDR) && (write_data == PASS_DATA);
    assign scratch_hit = (data_addr == SCRATCH_ADDR);

    always_comb begin
        state_nx  = state;
        latch_bad = 1'b0;
        case (state)
            S_RUN: begin
                if (write_enab && pass_hit) begin
                    state_nx = S_PASS;
                end else if (write_enab && !scratch_hit) begin
                    state_nx  = S_FAIL;
                    latch_bad = 1'b1;
                end else if (cycle_count == LAST_CYCLE) begin
                    state_nx = S_TIMEOUT;
                end
            end
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            store_count <= '0;
            cycle_count <= '0;
            bad_addr    <= '0;
            bad_data    <= '0;
        end else begin
            if (run) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (push && store_count != 16'hFFFF) begin
                store_count <= store_count + 16'd1;
            end
            if (latch_bad) begin
                bad_addr <= data_addr;
                bad_data <= write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            log_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
            if (push && !push_ok) begin
                log_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_addr[wr_ptr] <= data_addr;
            mem_data[wr_ptr] <= write_data;
        end
    end

    assign done     = !run;
    assign pass     = (state == S_PASS);
    assign fail     = (state == S_FAIL);
    assign timeout  = (state == S_TIMEOUT);
    assign log_addr = log_empty ? 32'd0 : mem_addr[rd_ptr];
    assign log_data = log_empty ? 32'd0 : mem_data[rd_ptr];

endmodule

// File: tb/tb_store_checker.sv
// Bench for store_checker: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_store_checker;

    localparam int TMO   = 20;
    localparam int DEPTH = 8;

    logic        clk;
    logic        reset;
    logic        write_enab;
    logic [31:0] data_addr;
    logic [31:0] write_data;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [15:0] store_count;
    logic [31:0] cycle_count;
    logic [31:0] bad_addr;
    logic [31:0] bad_data;
    logic        log_rd_en;
    logic        log_empty;
    logic        log_full;
    logic        log_overflow;
    logic [31:0] log_addr;
    logic [31:0] log_data;

    int checks = 0;
    int errors = 0;

    store_checker #(
        .TIMEOUT_CYCLES(TMO),
        .LOG_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .write_enab(write_enab),
        .data_addr(data_addr),
        .write_data(write_data),
        .done(done),
        .pass(pass),
        .fail(fail),
        .timeout(timeout),
        .store_count(store_count),
        .cycle_count(cycle_count),
        .bad_addr(bad_addr),
        .bad_data(bad_data),
        .log_rd_en(log_rd_en),
        .log_empty(log_empty),
        .log_full(log_full),
        .log_overflow(log_overflow),
        .log_addr(log_addr),
        .log_data(log_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    // Reference model: verdict as a small integer, log as a queue.
    localparam int M_RUN = 0;
    localparam int M_PASS = 1;
    localparam int M_FAIL = 2;
    localparam int M_TMO = 3;

    int          m_state;
    int unsigned m_scount;
    int unsigned m_cycle;
    logic [31:0] m_bad_a;
    logic [31:0] m_bad_d;
    bit          m_ovf;
    logic [63:0] m_q[$];

    task automatic model_step();
        bit          do_pop;
        int unsigned prev;
        if (reset) begin
            m_state  = M_RUN;
            m_scount = 0;
            m_cycle  = 0;
            m_bad_a  = 0;
            m_bad_d  = 0;
            m_ovf    = 0;
            m_q.delete();
            return;
        end
        do_pop = log_rd_en && (m_q.size() > 0);
        if (do_pop) void'(m_q.pop_front());
        if (m_state == M_RUN) begin
            prev = m_cycle;
            m_cycle = m_cycle + 1;
            if (write_enab) begin
                if (m_scount < 16'hFFFF) m_scount++;
                if (m_q.size() < DEPTH) m_q.push_back({data_addr, write_data});
                else m_ovf = 1;
                if (data_addr == 84 && write_data == 7) begin
                    m_state = M_PASS;
                end else if (data_addr != 80) begin
                    m_state = M_FAIL;
                    m_bad_a = data_addr;
                    m_bad_d = write_data;
                end else if (prev == TMO - 1) begin
                    m_state = M_TMO;
                end
            end else if (prev == TMO - 1) begin
                m_state = M_TMO;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("done", 32'(done), 32'(m_state != M_RUN));
            chk("pass", 32'(pass), 32'(m_state == M_PASS));
            chk("fail", 32'(fail), 32'(m_state == M_FAIL));
            chk("timeout", 32'(timeout), 32'(m_state == M_TMO));
            chk("store_count", 32'(store_count), m_scount);
            chk("cycle_count", cycle_count, m_cycle);
            chk("bad_addr", bad_addr, m_bad_a);
            chk("bad_data", bad_data, m_bad_d);
            chk("log_empty", 32'(log_empty), 32'(m_q.size() == 0));
            chk("log_full", 32'(log_full), 32'(m_q.size() == DEPTH));
            chk("log_overflow", 32'(log_overflow), 32'(m_ovf));
            if (m_q.size() > 0) begin
                chk("log_addr", log_addr, m_q[0][63:32]);
                chk("log_data", log_data, m_q[0][31:0]);
            end
        end
    end

    // Applies inputs at a falling edge and returns at the next one.
    task automatic step(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic rd);
        write_enab = we;
        data_addr  = a;
        write_data = d;
        log_rd_en  = rd;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset      = 1'b1;
        write_enab = 1'b0;
        data_addr  = '0;
        write_data = '0;
        log_rd_en  = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_fail"}, 32'(fail), 32'd0);
        chk({tag, "_tmo"}, 32'(timeout), 32'd0);
        chk({tag, "_scnt"}, 32'(store_count), 32'd0);
        chk({tag, "_ccnt"}, cycle_count, 32'd0);
        chk({tag, "_bada"}, bad_addr, 32'd0);
        chk({tag, "_badd"}, bad_data, 32'd0);
        chk({tag, "_empty"}, 32'(log_empty), 32'd1);
        chk({tag, "_full"}, 32'(log_full), 32'd0);
        chk({tag, "_ovf"}, 32'(log_overflow), 32'd0);
        chk({tag, "_laddr"}, log_addr, 32'd0);
        chk({tag, "_ldata"}, log_data, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        write_enab = 1'b0;
        data_addr  = '0;
        write_data = '0;
        log_rd_en  = 1'b0;

        // Scratch store then passing store.
        do_reset(2);
        chk_reset_state("t1_rst");
        step(1'b1, 32'd80, 32'd5, 1'b0);
        chk("t1_pass_early", 32'(pass), 32'd0);
        step(1'b1, 32'd84, 32'd7, 1'b0);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_scnt", 32'(store_count), 32'd2);
        chk("t1_head_a", log_addr, 32'd80);
        chk("t1_head_d", log_data, 32'd5);
        step(1'b0, 32'd0, 32'd0, 1'b1);
        chk("t1_next_a", log_addr, 32'd84);
        chk("t1_next_d", log_data, 32'd7);
        step(1'b0, 32'd0, 32'd0, 1'b1);
        chk("t1_empty", 32'(log_empty), 32'd1);
        step(1'b0, 32'd0, 32'd0, 1'b1);
        chk("t1_empty_pop", 32'(log_empty), 32'd1);

        // Wrong data at the pass address fails; later stores ignored.
        do_reset(1);
        step(1'b1, 32'd84, 32'd6, 1'b0);
        chk("t2_fail", 32'(fail), 32'd1);
        chk("t2_bada", bad_addr, 32'd84);
        chk("t2_badd", bad_data, 32'd6);
        step(1'b1, 32'd84, 32'd7, 1'b0);
        chk("t2_pass", 32'(pass), 32'd0);
        chk("t2_scnt", 32'(store_count), 32'd1);

        // Timeout with no stores.
        do_reset(1);
        repeat (TMO - 1) step(1'b0, 32'd0, 32'd0, 1'b0);
        chk("t3_tmo_early", 32'(timeout), 32'd0);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        chk("t3_tmo", 32'(timeout), 32'd1);
        chk("t3_ccnt", cycle_count, 32'd20);
        repeat (3) step(1'b1, 32'd84, 32'd7, 1'b0);
        chk("t3_frozen", cycle_count, 32'd20);
        chk("t3_scnt", 32'(store_count), 32'd0);

        // Passing store on the timeout edge wins.
        do_reset(1);
        repeat (TMO - 1) step(1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 32'd84, 32'd7, 1'b0);
        chk("t4_pass", 32'(pass), 32'd1);
        chk("t4_tmo", 32'(timeout), 32'd0);

        // Scratch store on the timeout edge does not prevent timeout.
        do_reset(1);
        repeat (TMO - 1) step(1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 32'd80, 32'd1, 1'b0);
        chk("t4b_tmo", 32'(timeout), 32'd1);

        // Overflow and in-order drain.
        do_reset(1);
        for (int i = 0; i < 10; i++) step(1'b1, 32'd80, 32'(i), 1'b0);
        chk("t5_full", 32'(log_full), 32'd1);
        chk("t5_ovf", 32'(log_overflow), 32'd1);
        chk("t5_scnt", 32'(store_count), 32'd10);
        for (int i = 0; i < 8; i++) begin
            chk("t5_drain", log_data, 32'(i));
            step(1'b0, 32'd0, 32'd0, 1'b1);
        end
        chk("t5_empty", 32'(log_empty), 32'd1);
        chk("t5_ovf_sticky", 32'(log_overflow), 32'd1);

        // Push and pop together while full, then reset mid-run.
        do_reset(1);
        for (int i = 0; i < 8; i++) step(1'b1, 32'd80, 32'(100 + i), 1'b0);
        chk("t6_full", 32'(log_full), 32'd1);
        step(1'b1, 32'd80, 32'd200, 1'b1);
        chk("t6_ovf", 32'(log_overflow), 32'd0);
        chk("t6_full2", 32'(log_full), 32'd1);
        chk("t6_head", log_data, 32'd101);
        chk("t6_scnt", 32'(store_count), 32'd9);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        do_reset(1);
        chk_reset_state("t6_rst");
        step(1'b0, 32'd0, 32'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
